// File: rtl/top.sv
// Counting-loop arithmetic kernel: a setup phase splits SETUP_CYCLES between bounds n and k,
// then "while (i <= n) { i++; j += i; }" runs one iteration per clock and the result is held.
module top #(
    parameter int W            = 13,
    parameter int SETUP_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         selector,
    output logic [W-1:0] i,
    output logic [W-1:0] j,
    output logic [W-1:0] k,
    output logic [W-1:0] n
);

    localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_LOOP  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  i_q, i_d;
    logic [W-1:0]  j_q, j_d;
    logic [W-1:0]  k_q, k_d;
    logic [W-1:0]  n_q, n_d;

    logic [W-1:0]  i_inc;
    logic          loop_go;

    assign i_inc   = i_q + W'(1);
    assign loop_go = (i_q <= n_q);

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        n_d     = n_q;

        unique case (state_q)
            ST_SETUP: begin
                if (selector) begin
                    n_d = n_q + W'(1);
                end else begin
                    k_d = k_q + W'(1);
                end
                // The final setup edge still applies its n/k update before leaving.
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_LOOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOOP: begin
                // j accumulates the already-incremented i, so j stays i(i+1)/2.
                if (loop_go) begin
                    i_d = i_inc;
                    j_d = j_q + i_inc;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_SETUP;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SETUP;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            n_q     <= n_d;
        end
    end

    assign i = i_q;
    assign j = j_q;
    assign k = k_q;
    assign n = n_q;

endmodule

// File: tb/tb_top.sv
// Directed and randomized checks of the counting-loop kernel: setup split, loop results,
// asynchronous mid-loop reset and DONE stability.
module tb_top;

    localparam int W  = 13;
    localparam int SC = 16;

    logic         clk;
    logic         rst;
    logic         selector;
    logic [W-1:0] i, j, k, n;

    int n_checks;
    int n_fail;

    top #(.W(W), .SETUP_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .i        (i),
        .j        (j),
        .k        (k),
        .n        (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset asserted and released on falling edges; leaves the bench at a falling edge.
    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Feeds one selector bit per rising edge for the whole setup phase.
    task automatic run_setup(input logic [SC-1:0] pattern);
        for (int c = 0; c < SC; c++) begin
            selector = pattern[c];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        selector = 1'b0;
        #3;
        n_checks++;
        if ({i, j, k, n} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got i=%0d j=%0d k=%0d n=%0d, want all 0", i, j, k, n);
        end
        @(negedge clk);
        n_checks++;
        if ({i, j, k, n} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got i=%0d j=%0d k=%0d n=%0d, want all 0", i, j, k, n);
        end
    endtask

    task automatic test_all_ones();
        apply_reset();
        run_setup(16'hFFFF);
        n_checks++;
        if (n !== 13'd16 || k !== 13'd0 || i !== 13'd0 || j !== 13'd0) begin
            n_fail++;
            $display("FAIL ones_setup: got i=%0d j=%0d k=%0d n=%0d, want i=0 j=0 k=0 n=16", i, j, k, n);
        end
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            n_checks++;
            if (i !== W'(e) || j !== W'(e * (e + 1) / 2)) begin
                n_fail++;
                $display("FAIL ones_loop_edge%0d: got i=%0d j=%0d, want i=%0d j=%0d", e, i, j, e, e * (e + 1) / 2);
            end
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (i !== 13'd17 || j !== 13'd153 || k !== 13'd0 || n !== 13'd16) begin
            n_fail++;
            $display("FAIL ones_done: got i=%0d j=%0d k=%0d n=%0d, want 17 153 0 16", i, j, k, n);
        end
        n_checks++;
        if (int'(i) + int'(j) + int'(k) <= 2 * int'(n)) begin
            n_fail++;
            $display("FAIL ones_invariant: got sum=%0d, want > %0d", int'(i) + int'(j) + int'(k), 2 * int'(n));
        end
    endtask

    task automatic test_all_zeros();
        apply_reset();
        run_setup(16'h0000);
        n_checks++;
        if (n !== 13'd0 || k !== 13'd16 || i !== 13'd0 || j !== 13'd0) begin
            n_fail++;
            $display("FAIL zeros_setup: got i=%0d j=%0d k=%0d n=%0d, want i=0 j=0 k=16 n=0", i, j, k, n);
        end
        @(negedge clk);
        n_checks++;
        if (i !== 13'd1 || j !== 13'd1) begin
            n_fail++;
            $display("FAIL zeros_first_edge: got i=%0d j=%0d, want i=1 j=1", i, j);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (i !== 13'd1 || j !== 13'd1 || k !== 13'd16 || n !== 13'd0) begin
            n_fail++;
            $display("FAIL zeros_done: got i=%0d j=%0d k=%0d n=%0d, want 1 1 16 0", i, j, k, n);
        end
        n_checks++;
        if (int'(i) + int'(j) + int'(k) != 18) begin
            n_fail++;
            $display("FAIL zeros_invariant: got sum=%0d, want 18 (> 0)", int'(i) + int'(j) + int'(k));
        end
    endtask

    task automatic test_alternating();
        apply_reset();
        run_setup(16'h5555);
        n_checks++;
        if (n !== 13'd8 || k !== 13'd8) begin
            n_fail++;
            $display("FAIL alt_setup: got k=%0d n=%0d, want k=8 n=8", k, n);
        end
        repeat (9) @(negedge clk);
        n_checks++;
        if (i !== 13'd9 || j !== 13'd45) begin
            n_fail++;
            $display("FAIL alt_latency: got i=%0d j=%0d after 9 edges, want i=9 j=45", i, j);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (i !== 13'd9 || j !== 13'd45 || k !== 13'd8 || n !== 13'd8) begin
            n_fail++;
            $display("FAIL alt_done: got i=%0d j=%0d k=%0d n=%0d, want 9 45 8 8", i, j, k, n);
        end
        n_checks++;
        if (int'(i) + int'(j) + int'(k) != 62) begin
            n_fail++;
            $display("FAIL alt_invariant: got sum=%0d, want 62 (> 16)", int'(i) + int'(j) + int'(k));
        end
    endtask

    task automatic test_reset_mid_loop();
        apply_reset();
        run_setup(16'hFFFF);
        repeat (5) @(negedge clk);
        n_checks++;
        if (i !== 13'd5 || j !== 13'd15) begin
            n_fail++;
            $display("FAIL midrst_pre: got i=%0d j=%0d, want i=5 j=15", i, j);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({i, j, k, n} !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got i=%0d j=%0d k=%0d n=%0d, want all 0 before clk", i, j, k, n);
        end
        @(negedge clk);
        rst = 1'b1;
        run_setup(16'h0000);
        n_checks++;
        if (i !== 13'd0 || k !== 13'd16 || n !== 13'd0) begin
            n_fail++;
            $display("FAIL midrst_full_setup: got i=%0d k=%0d n=%0d, want i=0 k=16 n=0", i, k, n);
        end
        @(negedge clk);
        n_checks++;
        if (i !== 13'd1 || j !== 13'd1) begin
            n_fail++;
            $display("FAIL midrst_loop: got i=%0d j=%0d, want i=1 j=1", i, j);
        end
    endtask

    task automatic test_done_stable();
        apply_reset();
        run_setup(16'hFFFF);
        repeat (20) @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            selector = ~selector;
            @(negedge clk);
            n_checks++;
            if (i !== 13'd17 || j !== 13'd153 || k !== 13'd0 || n !== 13'd16) begin
                n_fail++;
                $display("FAIL done_stable_c%0d: got i=%0d j=%0d k=%0d n=%0d, want 17 153 0 16", c, i, j, k, n);
            end
        end
    endtask

    // Small reference model: elapsed counts rising edges seen with reset released.
    task automatic test_random();
        int elapsed, n_m, k_m, i_m, j_m;
        apply_reset();
        elapsed = 0;
        n_m     = 0;
        k_m     = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            selector = 1'($urandom_range(0, 1));
            rst      = (cyc % 150 != 149);
            if (!rst) begin
                elapsed = 0;
                n_m     = 0;
                k_m     = 0;
            end
            @(negedge clk);
            if (rst) begin
                if (elapsed < SC) begin
                    if (selector) n_m++;
                    else          k_m++;
                end
                elapsed++;
            end
            i_m = (elapsed > SC) ? elapsed - SC : 0;
            if (i_m > n_m + 1) i_m = n_m + 1;
            j_m = i_m * (i_m + 1) / 2;

            n_checks++;
            if (i !== W'(i_m) || j !== W'(j_m) || k !== W'(k_m) || n !== W'(n_m)) begin
                n_fail++;
                $display("FAIL rand_c%0d: got i=%0d j=%0d k=%0d n=%0d, want %0d %0d %0d %0d",
                         cyc, i, j, k, n, i_m, j_m, k_m, n_m);
            end
            n_checks++;
            if (int'(j) != int'(i) * (int'(i) + 1) / 2 || int'(i) > int'(n) + 1) begin
                n_fail++;
                $display("FAIL rand_inv_c%0d: got i=%0d j=%0d n=%0d, want j=i(i+1)/2 and i<=n+1", cyc, i, j, n);
            end
            if (elapsed <= SC) begin
                n_checks++;
                if (int'(n) + int'(k) != elapsed) begin
                    n_fail++;
                    $display("FAIL rand_setup_c%0d: got n+k=%0d, want %0d", cyc, int'(n) + int'(k), elapsed);
                end
            end
            if (elapsed >= SC + n_m + 2) begin
                n_checks++;
                if (int'(i) != int'(n) + 1 || int'(i) + int'(j) + int'(k) <= 2 * int'(n)) begin
                    n_fail++;
                    $display("FAIL rand_done_c%0d: got i=%0d j=%0d k=%0d n=%0d, want i=n+1 and i+j+k>2n",
                             cyc, i, j, k, n);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        selector = 1'b0;
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_alternating();
        test_reset_mid_loop();
        test_done_stable();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Hardware model of a counting-loop arithmetic kernel (i, j, k, n).
- A setup phase builds non-negative bounds n and k from a 1-bit stimulus input, `selector`.
- A loop phase then runs "while (i <= n) { i = i + 1; j = j + i; }" at one iteration per clock.
- When the loop exits, all values are held so that property checkers can evaluate the invariant i + j + k > 2*n.
- Used as a standalone property-mining / invariant-checking target.

Parameters:
- W, 13, width of all data registers and outputs.
- SETUP_CYCLES, 16, number of clock cycles in the setup phase. Must satisfy (SETUP_CYCLES+1)(SETUP_CYCLES+2)/2 < 2^W.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- selector  input  1  stimulus bit, sampled only in the setup phase.
- i  output  W  loop counter register.
- j  output  W  running-sum register.
- k  output  W  free offset register built in setup.
- n  output  W  loop bound register built in setup.

Behaviour:
- Reset (rst=0, asynchronous, held while low):
  - i=0, j=0, k=0, n=0.
  - Internal setup counter = 0.
  - State = SETUP.
- Outputs are the registers directly; there is no combinational path from selector to any output.
- States: SETUP -> LOOP -> DONE. No other transitions except reset.
- SETUP (exactly SETUP_CYCLES rising edges after reset release):
  - Each edge: if selector=1, n <= n+1; else k <= k+1. Setup counter increments.
  - i and j are held at 0.
  - On the edge where the setup counter reaches SETUP_CYCLES-1, the state becomes LOOP; that edge still applies its n/k update.
  - Result: n + k = SETUP_CYCLES at the end of setup; both are always >= 0.
- LOOP:
  - Each edge, if i <= n (unsigned compare): i <= i+1 and j <= j + (i+1). Both update on the same edge; j uses the incremented i.
  - Each edge, if i > n: no register change, and the state becomes DONE.
  - n and k are frozen; selector is ignored.
  - Latency: n+1 update edges plus 1 exit edge.
- DONE:
  - All registers hold indefinitely; selector is ignored.
  - Only reset restarts the block.
- Final values: i = n+1 and j = (n+1)(n+2)/2.
- Invariant:
  - In every state after reset, i + j + k > 2*n holds at loop exit.
  - At any cycle, i <= n+1 and j = i(i+1)/2.
- Arithmetic:
  - All adds are W-bit, modulo 2^W, unsigned.
  - No overflow is reachable with legal parameters; no saturation logic is required.
- Reset mid-operation: asynchronous clear to the reset values in any state. Setup restarts from cycle 0 after release.
- Selector X/unknown in SETUP is a stimulus error; the design takes no special action.

Test Plan:
- selector=1 for all 16 setup cycles -> n=16, k=0. Loop runs 17 update edges. DONE holds i=17, j=153; check 170 > 32.
- selector=0 for all 16 setup cycles -> n=0, k=16. One update edge -> i=1, j=1, then DONE; check 18 > 0.
- selector alternating 1,0 for 16 cycles -> n=8, k=8. DONE holds i=9, j=45, k=8; check 62 > 16.
- Reset mid-loop: assert rst=0 while i=5 -> i, j, k, n read 0 immediately (before the next clk edge). After release, setup restarts with full 16-cycle count.
- 1000 cycles random selector, with reset re-pulsed periodically:
  - Every cycle check j = i(i+1)/2 and i <= n+1.
  - In SETUP, n + k equals elapsed setup cycles.
  - In DONE, i = n+1 and i + j + k > 2*n.
- DONE stability: after DONE, toggle selector for 100 cycles -> no output changes.
